fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_entry_t : one fetch-queue entry {pc, instr, misaligned}
//   fetch_state_t : fetch sequencer states
//   INSTR_BYTES   : PC increment per fetched instruction
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    INV_REQ  = 2'd1,
    INV_WAIT = 2'd2,
    HALT     = 2'd3
  } fetch_state_t;

  // A fetch target must be 4-byte aligned; anything else is a fault.
  function automatic logic is_misaligned(input logic [63:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: show-ahead queue of fetch entries feeding decode.
//   i_clk, i_reset : clock, synchronous active-high reset
//   push/push_data : enqueue (accepted when not full, or full with a pop)
//   pop            : dequeue head (ignored when empty)
//   flush          : empty the queue; a same-cycle push lands in the emptied queue
//   full, empty    : occupancy flags
//   head           : head entry, all-zero while empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW:0]    count_reg;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so decode never sees stale data.
  assign head = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      if (push) begin
        wr_ptr_reg <= AW'(1);
        count_reg  <= (AW+1)'(1);
      end else begin
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + (AW+1)'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - (AW+1)'(1);
    end
  end

  // Storage has no reset; the empty gating on head hides its contents.
  always_ff @(posedge i_clk) begin
    if (flush && push)          mem[0]          <= push_data;
    else if (!flush && do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between PC redirect sources and decode.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   o_ic_enable/o_ic_addr : icache request; address is always the current PC
//   i_ic_data/_ready      : icache hit data (combinational on o_ic_addr)
//   o_ic_invalidate       : one-cycle icache invalidate request (fence.i)
//   i_ic_invalidating     : icache invalidation still in progress
//   i_redirect/_pc        : redirect pulse and target (also fence.i resume PC)
//   i_fence_i             : fence.i pulse
//   o_dec_*               : head of the fetch queue; consumed on valid && ready
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_ic_enable,
  output logic [63:0] o_ic_addr,
  input  logic [31:0] i_ic_data,
  input  logic        i_ic_data_ready,
  output logic        o_ic_invalidate,
  input  logic        i_ic_invalidating,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  input  logic        i_fence_i,
  output logic        o_dec_valid,
  output logic [63:0] o_dec_pc,
  output logic [31:0] o_dec_instr,
  output logic        o_dec_misaligned,
  input  logic        i_dec_ready
);

  fetch_state_t state_reg;
  logic [63:0]  pc_reg;
  logic [63:0]  resume_pc_reg;
  logic         invalidate_reg;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_flush;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  logic         accepts_redirect;
  logic         hit_push;

  assign accepts_redirect = (state_reg == FETCH) || (state_reg == HALT);
  assign hit_push         = (state_reg == FETCH) && i_ic_data_ready && !fifo_full;

  assign o_ic_addr       = pc_reg;
  assign o_ic_enable     = (state_reg == FETCH) && !fifo_full;
  assign o_ic_invalidate = invalidate_reg;

  // Queue control. A flush discards any same-cycle pop; the only push that
  // survives a flush is the misaligned-fault marker.
  always_comb begin
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
    push_entry = '{pc: pc_reg, instr: i_ic_data, misaligned: 1'b0};
    if (accepts_redirect && i_fence_i) begin
      fifo_flush = 1'b1;
    end else if (accepts_redirect && i_redirect) begin
      fifo_flush = 1'b1;
      if (is_misaligned(i_redirect_pc)) begin
        fifo_push  = 1'b1;
        push_entry = '{pc: i_redirect_pc, instr: 32'h0, misaligned: 1'b1};
      end
    end else if (state_reg == INV_WAIT && !i_ic_invalidating) begin
      if (is_misaligned(resume_pc_reg)) begin
        fifo_push  = 1'b1;
        push_entry = '{pc: resume_pc_reg, instr: 32'h0, misaligned: 1'b1};
      end
    end else if (hit_push) begin
      fifo_push = 1'b1;
    end
  end

  assign fifo_pop = o_dec_valid && i_dec_ready && !fifo_flush;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      resume_pc_reg  <= '0;
      invalidate_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH, HALT: begin
          if (i_fence_i) begin
            resume_pc_reg  <= i_redirect_pc;
            invalidate_reg <= 1'b1;
            state_reg      <= INV_REQ;
          end else if (i_redirect) begin
            if (is_misaligned(i_redirect_pc)) begin
              state_reg <= HALT;
            end else begin
              pc_reg    <= i_redirect_pc;
              state_reg <= FETCH;
            end
          end else if (hit_push) begin
            pc_reg <= pc_reg + 64'(INSTR_BYTES);
          end
        end
        INV_REQ: begin
          invalidate_reg <= 1'b0;
          state_reg      <= INV_WAIT;
        end
        INV_WAIT: begin
          if (!i_ic_invalidating) begin
            if (is_misaligned(resume_pc_reg)) begin
              state_reg <= HALT;
            end else begin
              pc_reg    <= resume_pc_reg;
              state_reg <= FETCH;
            end
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign o_dec_valid      = !fifo_empty;
  assign o_dec_pc         = head.pc;
  assign o_dec_instr      = head.instr;
  assign o_dec_misaligned = head.misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by random traffic, every cycle
// checked against a queue-based reference model of the fetch stage.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        o_ic_enable;
  logic [63:0] o_ic_addr;
  logic [31:0] i_ic_data;
  logic        i_ic_data_ready;
  logic        o_ic_invalidate;
  logic        i_ic_invalidating;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        i_fence_i;
  logic        o_dec_valid;
  logic [63:0] o_dec_pc;
  logic [31:0] o_dec_instr;
  logic        o_dec_misaligned;
  logic        i_dec_ready;

  int compared   = 0;
  int mismatched = 0;

  always #5 i_clk = ~i_clk;

  // Icache stand-in: instruction word is a fixed hash of the address.
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
  endfunction

  assign i_ic_data = instr_of(o_ic_addr);

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .o_ic_enable       (o_ic_enable),
    .o_ic_addr         (o_ic_addr),
    .i_ic_data         (i_ic_data),
    .i_ic_data_ready   (i_ic_data_ready),
    .o_ic_invalidate   (o_ic_invalidate),
    .i_ic_invalidating (i_ic_invalidating),
    .i_redirect        (i_redirect),
    .i_redirect_pc     (i_redirect_pc),
    .i_fence_i         (i_fence_i),
    .o_dec_valid       (o_dec_valid),
    .o_dec_pc          (o_dec_pc),
    .o_dec_instr       (o_dec_instr),
    .o_dec_misaligned  (o_dec_misaligned),
    .i_dec_ready       (i_dec_ready)
  );

  // ---------------- reference model ----------------
  fetch_entry_t m_q[$];
  logic [63:0]  m_pc;
  logic [63:0]  m_resume;
  bit           m_halted;      // waiting for a redirect after a fault
  bit           m_inv_pulse;   // invalidate being requested this cycle
  bit           m_inv_wait;    // waiting for the icache to finish

  function automatic fetch_entry_t fault_entry(input logic [63:0] a);
    fetch_entry_t e;
    e.pc = a; e.instr = 32'h0; e.misaligned = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc = RESET_PC; m_resume = '0;
    m_halted = 0; m_inv_pulse = 0; m_inv_wait = 0;
  endtask

  task automatic model_edge();
    int size_before;
    fetch_entry_t e;
    if (i_reset) begin
      model_reset();
      return;
    end
    size_before = m_q.size();
    if (m_inv_pulse) begin
      m_inv_pulse = 0;
      m_inv_wait  = 1;
      if (i_dec_ready && size_before > 0) void'(m_q.pop_front());
    end else if (m_inv_wait) begin
      if (i_dec_ready && size_before > 0) void'(m_q.pop_front());
      if (!i_ic_invalidating) begin
        m_inv_wait = 0;
        if (m_resume[1:0] == 2'b00) m_pc = m_resume;
        else begin m_q.push_back(fault_entry(m_resume)); m_halted = 1; end
      end
    end else if (i_fence_i) begin
      m_q.delete();
      m_resume = i_redirect_pc;
      m_inv_pulse = 1;
      m_halted = 0;
    end else if (i_redirect) begin
      m_q.delete();
      if (i_redirect_pc[1:0] == 2'b00) begin m_pc = i_redirect_pc; m_halted = 0; end
      else begin m_q.push_back(fault_entry(i_redirect_pc)); m_halted = 1; end
    end else begin
      if (i_dec_ready && size_before > 0) void'(m_q.pop_front());
      if (!m_halted && i_ic_data_ready && size_before < DEPTH) begin
        e.pc = m_pc; e.instr = instr_of(m_pc); e.misaligned = 1'b0;
        m_q.push_back(e);
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    fetch_entry_t h;
    bit en;
    h  = (m_q.size() > 0) ? m_q[0] : '0;
    en = !m_halted && !m_inv_pulse && !m_inv_wait && (m_q.size() < DEPTH);
    chk("ic_addr",       o_ic_addr,        m_pc);
    chk("ic_enable",     64'(o_ic_enable), 64'(en));
    chk("ic_invalidate", 64'(o_ic_invalidate), 64'(m_inv_pulse));
    chk("dec_valid",     64'(o_dec_valid), 64'(m_q.size() > 0));
    chk("dec_pc",        o_dec_pc,         h.pc);
    chk("dec_instr",     64'(o_dec_instr), 64'(h.instr));
    chk("dec_misalign",  64'(o_dec_misaligned), 64'(h.misaligned));
  endtask

  // One clock: inputs are already driven; update model at the edge, check 1 ns later.
  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    i_ic_data_ready = 0; i_ic_invalidating = 0; i_redirect = 0;
    i_redirect_pc = '0; i_fence_i = 0; i_dec_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1;
    step(); step();
    i_reset = 0;
  endtask

  int pulses;
  int enables;

  initial begin
    model_reset();
    idle_inputs();
    i_reset = 1;

    // Reset state
    step(); step();
    chk("rst_valid", 64'(o_dec_valid), 64'd0);
    chk("rst_addr",  o_ic_addr, RESET_PC);
    chk("rst_inv",   64'(o_ic_invalidate), 64'd0);
    chk("rst_pc",    o_dec_pc, 64'd0);
    i_reset = 0;

    // Hits on 0x0, 0x4, 0x8 with decode ready: each visible one cycle later
    i_ic_data_ready = 1; i_dec_ready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lat_pc",    o_dec_pc, 64'(4 * k));
      chk("lat_instr", 64'(o_dec_instr), 64'(instr_of(64'(4 * k))));
    end
    $display("txn: sequential hits 0x0/0x4/0x8");

    // Backpressure: queue fills with 0x0..0xC, pc holds at 0x10
    do_reset();
    i_ic_data_ready = 1; i_dec_ready = 0;
    repeat (7) step();
    chk("full_addr",   o_ic_addr, 64'h10);
    chk("full_enable", 64'(o_ic_enable), 64'd0);
    chk("full_head",   o_dec_pc, 64'h0);
    i_dec_ready = 1;
    repeat (6) step();
    $display("txn: full stall then drain");

    // Redirect to 0x1000 in the same cycle as the hit on 0x8
    do_reset();
    i_ic_data_ready = 1; i_dec_ready = 0;
    step(); step();
    i_redirect = 1; i_redirect_pc = 64'h1000;
    step();
    i_redirect = 0;
    chk("redir_addr",  o_ic_addr, 64'h1000);
    chk("redir_valid", 64'(o_dec_valid), 64'd0);
    $display("txn: redirect 0x1000 over hit 0x8");

    // Misaligned redirect 0x1002 then recovery at 0x2000
    i_redirect = 1; i_redirect_pc = 64'h1002;
    step();
    i_redirect = 0;
    chk("mis_pc",     o_dec_pc, 64'h1002);
    chk("mis_flag",   64'(o_dec_misaligned), 64'd1);
    chk("mis_enable", 64'(o_ic_enable), 64'd0);
    repeat (3) step();
    i_redirect = 1; i_redirect_pc = 64'h2000;
    step();
    i_redirect = 0;
    chk("resume_addr", o_ic_addr, 64'h2000);
    $display("txn: misaligned redirect 0x1002, resume 0x2000");

    // fence.i with resume 0x40, invalidation busy for 65 cycles
    i_dec_ready = 1;
    i_fence_i = 1; i_redirect_pc = 64'h40; i_ic_invalidating = 1;
    pulses = 0; enables = 0;
    step();
    i_fence_i = 0; i_redirect_pc = '0;
    pulses += int'(o_ic_invalidate); enables += int'(o_ic_enable);
    for (int k = 0; k < 65; k++) begin
      step();
      pulses += int'(o_ic_invalidate); enables += int'(o_ic_enable);
    end
    chk("fence_pulses",  64'(pulses), 64'd1);
    chk("fence_enables", 64'(enables), 64'd0);
    i_ic_invalidating = 0;
    step();
    chk("fence_resume", o_ic_addr, 64'h40);
    $display("txn: fence.i resume 0x40");

    // Reset during INV_WAIT
    i_fence_i = 1; i_redirect_pc = 64'h80; i_ic_invalidating = 1;
    step();
    i_fence_i = 0;
    step(); step();
    i_reset = 1;
    step();
    chk("rst_inv_addr",  o_ic_addr, RESET_PC);
    chk("rst_inv_valid", 64'(o_dec_valid), 64'd0);
    i_reset = 0; i_ic_invalidating = 0;
    step(); step();
    $display("txn: reset during invalidate wait");

    // Random traffic, including redirects near the top of the address space
    for (int n = 0; n < 800; n++) begin
      i_ic_data_ready   = ($urandom_range(0, 9) < 7);
      i_dec_ready       = ($urandom_range(0, 9) < 6);
      i_ic_invalidating = ($urandom_range(0, 9) < 7);
      i_redirect        = ($urandom_range(0, 99) < 5);
      i_fence_i         = ($urandom_range(0, 99) < 2);
      i_redirect_pc     = 64'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 9) == 0) i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFF4;
      if ($urandom_range(0, 3) == 0) i_redirect_pc[1:0] = 2'($urandom_range(1, 3));
      step();
      if (n % 100 == 99) $display("txn: random block %0d done", n / 100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
